ram_port_arbiter: RTL
=====================

# ram_port_arbiter

Two-master arbiter that shares the single-port data RAM (with its GPIO window at 0x100 input / 0x101 output) between the CPU datapath (m0) and a second master such as a loader or debug engine (m1). It selects one request per cycle using round-robin order. A lock option lets one master run burst accesses, with a cap that prevents starvation. It drives the RAM's clk/addr/din/we port and routes the RAM's one-cycle-latency read data back to the master that issued the read. The arbiter does no address decoding; GPIO addresses pass through unchanged.

## Interface
Parameters:
- DW, 16, data width (matches RAM)
- AW, 13, address width (matches RAM)
- MAX_BURST, 8, maximum consecutive locked grants to one master while the other is requesting (≥1)

Ports (mX = m0, m1; each has an identical set):
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  system clock; same clock as the RAM
  - rst_n  in  1  asynchronous, active-low reset
- mX_req  in  1  access request; held until granted
- mX_we  in  1  1 = write, 0 = read
- mX_lock  in  1  request to keep the grant on the next cycle (burst)
- mX_addr  in  AW  word address
- mX_wdata  in  DW  write data
- mX_gnt  out  1  access accepted this cycle; combinational
- mX_rvalid  out  1  read data valid for mX; registered
- rdata  out  DW  shared read data; equals ram_dout
- ram_addr  out  AW  to RAM addr
- ram_din  out  DW  to RAM din
- ram_we  out  1  to RAM we
- ram_dout  in  DW  from RAM dout

## Operation
- **Grant rule.** A transfer happens in any cycle where mX_req=1 and mX_gnt=1. The RAM samples the access at the closing posedge. At most one gnt is high per cycle.
- **Arbitration with a single requester.** That master is granted immediately.
- **Arbitration with both requesting.**
  - Not in a burst: grant the master opposite to last_owner.
  - In a burst: grant last_owner if last_owner made a locked grant the previous cycle, still has req=1, and burst_cnt < MAX_BURST.
- **Registered state:**
  - last_owner (1b): reset value 0, so m1 wins the first contention.
  - burst_cnt: counts consecutive grants to the same master. It resets to 1 when ownership changes. It resets to 0 when a cycle has no grant.
- **Burst cap.** When burst_cnt reaches MAX_BURST and the other master is requesting, the other master is granted next. With no competitor, a locked master is never cut off.
- **RAM drive.**
  - Granted cycle: ram_addr/ram_din/ram_we = winner's addr/wdata/we.
  - No grant: ram_we=0, ram_addr=0, ram_din=0. This performs a harmless read of address 0.
- **Read return.** rd_pend (1b) and rd_id (1b) are registered when a read is granted. On the next cycle mX_rvalid=1 for rd_id only, and rdata=ram_dout. Writes generate no rvalid.
- **Back-to-back reads.** Supported at one per cycle, including alternating masters. Each rvalid follows its own grant by one cycle.
- **Read then write.** The RAM holds its read address on write cycles, so rvalid data stays correct when the next cycle is a granted write.
- **Reset.** While rst_n=0: all gnt=0, ram_we=0, rvalid=0, last_owner=0, burst_cnt=0. Reset asserted mid-operation discards a pending read; no rvalid follows after reset release.

## Timing
- Grant latency: 0 cycles. gnt is combinational from req and registered state, with no combinational path from mX_addr/mX_we to gnt.
- Read latency: rvalid and rdata appear 1 cycle after the grant cycle.
- Throughput: 1 access per cycle.
- Worst-case wait for a requesting master: MAX_BURST cycles.
- Timing path: ram_dout feeds rdata combinationally; the RAM read path already ends in the RAM's address register.
- Write visibility: a write granted in cycle N is visible to a read granted in cycle N+1, whose rvalid is in cycle N+2.

## Structure
- Shared package `yduck_mem_pkg`:
  - master-ID constants M0=0, M1=1
  - GPI_A=16'h100 and GPO_A=16'h101, for bench and other masters
  - default MAX_BURST
- Sub-module `arb_rr2`:
  - contains the two-way round-robin pick, last_owner and burst_cnt
  - outputs a one-hot grant
- The top level keeps the port mux and the read-return pipe.

## Test plan
- **Single master.** m0 reads 0x005 after an m1 write of 0xBEEF to 0x005 → m0_gnt in the same cycle; m0_rvalid=1 with rdata=0xBEEF one cycle later; m1_rvalid stays 0.
- **Contention.** m0 and m1 hold req continuously, both unlocked → grants alternate m1, m0, m1, m0 from reset.
- **Burst cap.** m1 locks with MAX_BURST=8 while m0 requests throughout → m1 gets exactly 8 consecutive grants, then m0 is granted. With m0 idle, m1 is granted for 20 consecutive cycles.
- **Mixed pipeline.** m0 reads 0x010 in cycle N and m1 writes 0x010 in cycle N+1 → m0_rvalid in N+1 returns the old value. m0 rereads in N+2 → rvalid in N+3 returns the new value.
- **GPIO passthrough.** m1 writes 0x00A5 to 0x101 → RAM gpio_out=0x00A5. m0 then reads 0x100 with gpio_in=0x1234 → rdata=0x1234.
- **Reset mid-read.** rst_n is pulsed low in the cycle after a read grant → no rvalid during or after reset. After release, a fresh contention grants m1 first.

Source files
------------

// File: rtl/yduck_mem_pkg.sv
// rtl/yduck_mem_pkg.sv - shared memory-port constants and master IDs
package yduck_mem_pkg;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } mid_e;

  localparam logic [15:0] GPI_A         = 16'h100;
  localparam logic [15:0] GPO_A         = 16'h101;
  localparam int          DEF_MAX_BURST = 8;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - one master's request/grant/read-valid bundle
interface ram_port_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 13
);
  logic          req;
  logic          we;
  logic          lock;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;

  modport master (output req, we, lock, addr, wdata, input gnt, rvalid);
  modport slave  (input req, we, lock, addr, wdata, output gnt, rvalid);
endinterface

// File: rtl/arb_rr2.sv
// rtl/arb_rr2.sv - two-way round-robin pick with lockable bursts and a burst cap
module arb_rr2
  import yduck_mem_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic [1:0] lock_i,
  output logic [1:0] gnt_o
);
  localparam int CW = $clog2(MAX_BURST + 1);

  mid_e          last_owner_q, last_owner_d, win_id;
  logic [CW-1:0] burst_cnt_q, burst_cnt_d;
  logic          locked_q, locked_d;
  logic          any_gnt, hold;

  // lock only acts through locked_q, so gnt never depends on this cycle's lock/addr/we
  always_comb begin
    hold    = locked_q && req_i[last_owner_q] && (burst_cnt_q < CW'(MAX_BURST));
    any_gnt = 1'b1;
    win_id  = M0;
    case (req_i)
      2'b01:   win_id = M0;
      2'b10:   win_id = M1;
      2'b11:   win_id = hold ? last_owner_q : mid_e'(~last_owner_q);
      default: any_gnt = 1'b0;
    endcase
    gnt_o = 2'b00;
    if (any_gnt && rst_n) gnt_o = (win_id == M1) ? 2'b10 : 2'b01;
  end

  always_comb begin
    last_owner_d = last_owner_q;
    burst_cnt_d  = '0;
    locked_d     = 1'b0;
    if (any_gnt) begin
      last_owner_d = win_id;
      locked_d     = lock_i[win_id];
      if (win_id != last_owner_q)               burst_cnt_d = CW'(1);
      else if (burst_cnt_q == CW'(MAX_BURST))   burst_cnt_d = burst_cnt_q;
      else                                      burst_cnt_d = burst_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= M0;
      burst_cnt_q  <= '0;
      locked_q     <= 1'b0;
    end else begin
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      locked_q     <= locked_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - shares the single-port data RAM between two masters
// Muxes the winner onto the RAM port and steers one-cycle-latency read data back.
module ram_port_arbiter
  import yduck_mem_pkg::*;
#(
  parameter int DW        = 16,
  parameter int AW        = 13,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                rst_n,
  ram_port_arbiter_if.slave   m0,
  ram_port_arbiter_if.slave   m1,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       ram_addr,
  output logic [DW-1:0]       ram_din,
  output logic                ram_we,
  input  logic [DW-1:0]       ram_dout
);
  logic [1:0] gnt;
  logic       rd_pend_q, rd_pend_d;
  mid_e       rd_id_q, rd_id_d;

  arb_rr2 #(.MAX_BURST(MAX_BURST)) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  ({m1.req, m0.req}),
    .lock_i ({m1.lock, m0.lock}),
    .gnt_o  (gnt)
  );

  assign m0.gnt = gnt[0];
  assign m1.gnt = gnt[1];

  // Idle cycles issue a read of address 0 so the RAM port is never left undriven
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (gnt[0]) begin
      ram_we   = m0.we;
      ram_addr = m0.addr;
      ram_din  = m0.wdata;
    end else if (gnt[1]) begin
      ram_we   = m1.we;
      ram_addr = m1.addr;
      ram_din  = m1.wdata;
    end
  end

  always_comb begin
    rd_pend_d = (|gnt) && !ram_we;
    rd_id_d   = gnt[1] ? M1 : M0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      rd_id_q   <= M0;
    end else begin
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
    end
  end

  assign m0.rvalid = rd_pend_q && (rd_id_q == M0);
  assign m1.rvalid = rd_pend_q && (rd_id_q == M1);
  assign rdata     = ram_dout;

endmodule
